// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline latch: state encoding, occupancy
// codes and small decode helpers used by the latch and its bench.
package pipe_pkg;

    typedef enum logic [1:0] {
        P_EMPTY = 2'd0,
        P_ONE   = 2'd1,
        P_FULL  = 2'd2,
        P_HALT  = 2'd3
    } pstate_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // A halted latch reports no held entries even though it never drains.
    function automatic logic [1:0] occ_of(input pstate_t s);
        logic [1:0] occ;
        case (s)
            P_ONE:   occ = OCC_ONE;
            P_FULL:  occ = OCC_FULL;
            default: occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

    function automatic logic can_accept(input pstate_t s);
        return (s == P_EMPTY) || (s == P_ONE);
    endfunction

    function automatic logic has_head(input pstate_t s);
        return (s == P_ONE) || (s == P_FULL);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_skid_latch.sv
// Inter-stage pipeline latch: valid/ready payload register with a one-entry
// skid, synchronous flush, sticky halt and stall/flush performance counters.
module pipe_skid_latch
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              halt,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pstate_t           r_state;
    logic [DATA_W-1:0] r_main_data;
    logic              r_main_halt;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_halt;
    logic              r_in_ready;
    logic              r_out_valid;

    pstate_t           w_state_next;
    logic              w_push;
    logic              w_pop;
    logic              w_main_load;
    logic              w_main_from_skid;
    logic              w_skid_load;
    logic [DATA_W-1:0] w_main_data_next;
    logic              w_main_halt_next;
    logic              w_stall;

    // Handshake terms come only from flops on our side, so in_ready never
    // depends combinationally on out_ready.
    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;

        if (r_state != P_HALT && w_pop && r_main_halt) begin
            // Consuming a halting payload freezes the stage; skid and any
            // same-cycle push are abandoned, and this beats a flush.
            w_state_next = P_HALT;
        end else if (r_state != P_HALT && flush) begin
            w_state_next = P_EMPTY;
        end else begin
            case (r_state)
                P_EMPTY: begin
                    if (w_push) begin
                        w_state_next = P_ONE;
                        w_main_load  = 1'b1;
                    end
                end
                P_ONE: begin
                    if (w_push && w_pop) begin
                        w_main_load = 1'b1;
                    end else if (w_push) begin
                        w_state_next = P_FULL;
                        w_skid_load  = 1'b1;
                    end else if (w_pop) begin
                        w_state_next = P_EMPTY;
                    end
                end
                P_FULL: begin
                    if (w_pop) begin
                        w_state_next     = P_ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = P_HALT;
                end
            endcase
        end
    end

    assign w_main_data_next = w_main_from_skid ? r_skid_data : in_data;
    assign w_main_halt_next = w_main_from_skid ? r_skid_halt : in_halt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= P_EMPTY;
            r_main_data <= '0;
            r_main_halt <= 1'b0;
            r_skid_data <= '0;
            r_skid_halt <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= can_accept(w_state_next);
            r_out_valid <= has_head(w_state_next);
            if (w_main_load) begin
                r_main_data <= w_main_data_next;
                r_main_halt <= w_main_halt_next;
            end
            if (w_skid_load) begin
                r_skid_data <= in_data;
                r_skid_halt <= in_halt;
            end
        end
    end

    assign w_stall = r_out_valid & ~out_ready;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_stall),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush),
        .count (flush_cnt)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main_data;
    assign halt      = (r_state == P_HALT);
    assign occupancy = occ_of(r_state);

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed bench for pipe_skid_latch: streaming, backpressure, flush, halt,
// asynchronous reset and counter saturation on a narrow-counter instance.
module tb_pipe_skid_latch;

    logic         CLK;
    logic         RST;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_halt;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         halt;
    logic         flush;
    logic [1:0]   occupancy;
    logic [15:0]  stall_cnt;
    logic [15:0]  flush_cnt;

    logic         b_in_valid;
    logic         b_in_ready;
    logic [7:0]   b_in_data;
    logic         b_in_halt;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [7:0]   b_out_data;
    logic         b_halt;
    logic         b_flush;
    logic [1:0]   b_occupancy;
    logic [1:0]   b_stall_cnt;
    logic [1:0]   b_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_skid_latch #(
        .DATA_W (128),
        .CNT_W  (16)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_halt   (in_halt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .halt      (halt),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    pipe_skid_latch #(
        .DATA_W (8),
        .CNT_W  (2)
    ) u_dut_narrow (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_halt   (b_in_halt),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .halt      (b_halt),
        .flush     (b_flush),
        .occupancy (b_occupancy),
        .stall_cnt (b_stall_cnt),
        .flush_cnt (b_flush_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        in_valid = 1'b0; in_data = '0; in_halt = 1'b0; out_ready = 1'b0; flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_halt = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
        step();
        step();

        chk_eq("rst_in_ready", in_ready, 1);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_occ", occupancy, 0);
        chk_eq("rst_halt", halt, 0);
        chk_eq("rst_stall", stall_cnt, 0);
        chk_eq("rst_flush", flush_cnt, 0);
        chk_eq("rst_out_data", out_data, 0);
        RST = 1'b0;

        // 1: streaming at one beat per cycle, one cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 128'(i);
            step();
            chk_eq($sformatf("stream_data_%0d", i), out_data, 128'(i));
            chk_eq($sformatf("stream_occ_%0d", i), occupancy, 1);
        end
        in_valid = 1'b0;
        step();
        chk_eq("stream_drain_valid", out_valid, 0);
        chk_eq("stream_stall", stall_cnt, 0);

        // 2: backpressure fills the skid, then drains in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'hA;
        step();
        in_data = 128'hB;
        step();
        chk_eq("bp_occ_full", occupancy, 2);
        chk_eq("bp_in_ready", in_ready, 0);
        in_data = 128'hC;
        step();
        chk_eq("bp_head_held", out_data, 128'hA);
        chk_eq("bp_stall_held", stall_cnt, 2);
        out_ready = 1'b1;
        step();
        chk_eq("bp_out_b", out_data, 128'hB);
        chk_eq("bp_occ_one", occupancy, 1);
        step();
        chk_eq("bp_out_c", out_data, 128'hC);
        in_valid = 1'b0;
        step();
        chk_eq("bp_empty", occupancy, 0);
        chk_eq("bp_stall_total", stall_cnt, 2);

        // 3: flush in P_FULL drops everything including the offered 0xD
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h1;
        step();
        in_data = 128'h2;
        step();
        in_data = 128'hD;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        chk_eq("fl_occ", occupancy, 0);
        chk_eq("fl_out_valid", out_valid, 0);
        chk_eq("fl_cnt", flush_cnt, 1);
        chk_eq("fl_in_ready", in_ready, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk_eq("fl_no_d", out_valid, 0);
        // flush in P_ONE with a same-cycle push: pop completes, push dropped
        in_valid = 1'b1;
        in_data  = 128'hE;
        step();
        chk_eq("fl_e_head", out_data, 128'hE);
        in_data = 128'hF;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_eq("fl_push_dropped", out_valid, 0);
        chk_eq("fl_cnt2", flush_cnt, 2);
        chk_eq("fl_stall", stall_cnt, 4);

        // 4: halt payload consumed, following entry discarded
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h5;
        in_halt   = 1'b1;
        step();
        in_data = 128'h6;
        in_halt = 1'b0;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk_eq("halt_set", halt, 1);
        chk_eq("halt_out_valid", out_valid, 0);
        chk_eq("halt_in_ready", in_ready, 0);
        chk_eq("halt_occ", occupancy, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_eq("halt_after_flush", halt, 1);
        chk_eq("halt_flush_cnt", flush_cnt, 3);
        in_valid = 1'b1;
        in_data  = 128'h7;
        step();
        step();
        chk_eq("halt_no_6", out_valid, 0);
        chk_eq("halt_stall", stall_cnt, 5);
        in_valid = 1'b0;
        RST = 1'b1;
        #2;
        chk_eq("halt_rst_clear", halt, 0);
        chk_eq("halt_rst_ready", in_ready, 1);
        chk_eq("halt_rst_flush", flush_cnt, 0);
        RST = 1'b0;

        // 5: async reset mid-cycle while full
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h11;
        step();
        in_data = 128'h22;
        step();
        chk_eq("ar_full", occupancy, 2);
        in_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk_eq("ar_occ", occupancy, 0);
        chk_eq("ar_out_valid", out_valid, 0);
        chk_eq("ar_in_ready", in_ready, 1);
        chk_eq("ar_out_data", out_data, 0);
        chk_eq("ar_stall", stall_cnt, 0);
        #1;
        RST = 1'b0;

        // 6: 2-bit counters saturate at 3
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 8'h77;
        step();
        b_in_valid = 1'b0;
        chk_eq("sat_head", b_out_data, 8'h77);
        step();
        step();
        chk_eq("sat_stall_2", b_stall_cnt, 2);
        for (int i = 0; i < 4; i++) step();
        chk_eq("sat_stall_max", b_stall_cnt, 3);
        b_flush = 1'b1;
        for (int i = 0; i < 5; i++) step();
        b_flush = 1'b0;
        chk_eq("sat_flush_max", b_flush_cnt, 3);
        chk_eq("sat_flush_empty", b_occupancy, 0);
        chk_eq("sat_wide_untouched", flush_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
